// File: rtl/mandel_scanner_if.sv
// Handshake bundle between the raster scanner, the Mandelbrot iterator and the frame-buffer writer.
// Pure wiring, no latency.
// Both channels are valid/ready; master = scanner side, slave = iterator/frame-buffer side.
interface mandel_scanner_if #(
    parameter int CW = 27,
    parameter int IW = 11,
    parameter int AW = 19
);
    // coordinate channel towards the iterator
    logic          it_val;
    logic          it_rdy;
    logic [CW-1:0] it_c_r;
    logic [CW-1:0] it_c_i;
    // result channel back from the iterator
    logic          it_out_val;
    logic          it_out_rdy;
    logic [IW-1:0] it_iter_count;
    logic          it_escape;
    // tagged pixel result towards the frame buffer
    logic          pix_val;
    logic          pix_rdy;
    logic [AW-1:0] pix_addr;
    logic [IW-1:0] pix_iter;
    logic          pix_escape;

    modport master (
        output it_val, it_c_r, it_c_i, it_out_rdy,
        output pix_val, pix_addr, pix_iter, pix_escape,
        input  it_rdy, it_out_val, it_iter_count, it_escape, pix_rdy
    );

    modport slave (
        input  it_val, it_c_r, it_c_i, it_out_rdy,
        input  pix_val, pix_addr, pix_iter, pix_escape,
        output it_rdy, it_out_val, it_iter_count, it_escape, pix_rdy
    );
endinterface

// File: rtl/mandel_scanner.sv
// Raster-scan sequencer: walks an H_PIX x V_PIX frame, feeds each coordinate to the iterator, tags results with an address.
// Latency: 3 cycles per pixel on top of iterator latency (issue, result capture, pixel write); all outputs registered.
// Backpressure: it_val / pix_val are held with stable data until their ready; one pixel in flight at a time.
module mandel_scanner #(
    parameter int H_PIX    = 640,
    parameter int V_PIX    = 480,
    parameter int ITER_MAX = 1000,
    parameter int CW       = 27
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] x0,
    input  logic [CW-1:0] y0,
    input  logic [CW-1:0] dx,
    input  logic [CW-1:0] dy,
    output logic          busy,
    output logic          frame_done,
    mandel_scanner_if.master bus
);
    localparam int IW  = $clog2(ITER_MAX) + 1;
    localparam int AW  = $clog2(H_PIX * V_PIX);
    localparam int CLW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
    localparam int RWW = (V_PIX > 1) ? $clog2(V_PIX) : 1;

    localparam logic [CLW-1:0] COL_LAST = CLW'(H_PIX - 1);
    localparam logic [RWW-1:0] ROW_LAST = RWW'(V_PIX - 1);
    localparam logic [CLW-1:0] COL_ONE  = CLW'(1);
    localparam logic [RWW-1:0] ROW_ONE  = RWW'(1);
    localparam logic [AW-1:0]  ADDR_ONE = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE
    } state_t;

    state_t         state;
    logic           abort_flag;
    logic [CLW-1:0] col;
    logic [RWW-1:0] row;
    logic [CW-1:0]  x0_l;
    logic [CW-1:0]  dx_l;
    logic [CW-1:0]  dy_l;
    logic           stop_req;

    // An abort seen this cycle or remembered from earlier both end the frame at the next safe point.
    assign stop_req = abort | abort_flag;

    // Frame sequencer: state, scan counters, coordinate accumulators and all handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            abort_flag     <= 1'b0;
            col            <= '0;
            row            <= '0;
            x0_l           <= '0;
            dx_l           <= '0;
            dy_l           <= '0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            bus.it_val     <= 1'b0;
            bus.it_c_r     <= '0;
            bus.it_c_i     <= '0;
            bus.it_out_rdy <= 1'b0;
            bus.pix_val    <= 1'b0;
            bus.pix_addr   <= '0;
            bus.pix_iter   <= '0;
            bus.pix_escape <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state != S_IDLE && abort) begin
                abort_flag <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    abort_flag <= 1'b0;
                    if (start) begin
                        x0_l         <= x0;
                        dx_l         <= dx;
                        dy_l         <= dy;
                        col          <= '0;
                        row          <= '0;
                        bus.pix_addr <= '0;
                        bus.it_c_r   <= x0;
                        bus.it_c_i   <= y0;
                        bus.it_val   <= 1'b1;
                        busy         <= 1'b1;
                        state        <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // A coordinate already accepted must be drained, so the handshake wins over abort.
                    if (bus.it_val && bus.it_rdy) begin
                        bus.it_val     <= 1'b0;
                        bus.it_out_rdy <= 1'b1;
                        state          <= S_WAIT;
                    end else if (stop_req) begin
                        bus.it_val <= 1'b0;
                        busy       <= 1'b0;
                        abort_flag <= 1'b0;
                        state      <= S_IDLE;
                    end
                end

                S_WAIT: begin
                    if (bus.it_out_val && bus.it_out_rdy) begin
                        bus.it_out_rdy <= 1'b0;
                        if (stop_req) begin
                            // Result swallowed: the frame buffer never sees an aborted pixel.
                            busy       <= 1'b0;
                            abort_flag <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            bus.pix_iter   <= IW'(bus.it_iter_count);
                            bus.pix_escape <= bus.it_escape;
                            bus.pix_val    <= 1'b1;
                            state          <= S_WRITE;
                        end
                    end
                end

                S_WRITE: begin
                    if (bus.pix_val && bus.pix_rdy) begin
                        bus.pix_val <= 1'b0;
                        if (stop_req) begin
                            busy       <= 1'b0;
                            abort_flag <= 1'b0;
                            state      <= S_IDLE;
                        end else if (col != COL_LAST) begin
                            col          <= col + COL_ONE;
                            bus.it_c_r   <= bus.it_c_r + dx_l;
                            bus.pix_addr <= bus.pix_addr + ADDR_ONE;
                            bus.it_val   <= 1'b1;
                            state        <= S_ISSUE;
                        end else if (row != ROW_LAST) begin
                            // Row wrap: real part restarts from the latched origin, imaginary part steps.
                            col          <= '0;
                            row          <= row + ROW_ONE;
                            bus.it_c_r   <= x0_l;
                            bus.it_c_i   <= bus.it_c_i + dy_l;
                            bus.pix_addr <= bus.pix_addr + ADDR_ONE;
                            bus.it_val   <= 1'b1;
                            state        <= S_ISSUE;
                        end else begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= S_IDLE;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mandel_scanner.sv
// Directed bench for mandel_scanner on a 4x2 frame with the iterator and frame buffer played by the bench.
// Every step samples 1 ns after the rising edge and drives inputs at the same point.
// Covers full frames with stalls, abort in each state, wrap-around, start-while-busy and async reset.
module tb_mandel_scanner;
    localparam int CW = 27;
    localparam int IW = 11;
    localparam int AW = 3;

    logic          clk;
    logic          reset;
    logic          start;
    logic          abort;
    logic [CW-1:0] x0, y0, dx, dy;
    logic          busy;
    logic          frame_done;

    mandel_scanner_if #(.CW(CW), .IW(IW), .AW(AW)) bus ();

    mandel_scanner #(
        .H_PIX(4), .V_PIX(2), .ITER_MAX(1000), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .x0(x0), .y0(y0), .dx(dx), .dy(dy),
        .busy(busy), .frame_done(frame_done), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int fd_count = 0;
    int pix_cnt  = 0;

    // frame_done pulses and cycles with pix_val high, observed independently of the sequences
    always @(posedge clk) begin
        if (reset && frame_done) fd_count++;
        if (reset && bus.pix_val) pix_cnt++;
    end

    typedef struct {
        logic [CW-1:0] c_r;
        logic [CW-1:0] c_i;
        logic [IW-1:0] iter;
        logic          esc;
        int            rdy_stall;
        int            pix_stall;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [CW-1:0] sx0, input logic [CW-1:0] sy0,
                               input logic [CW-1:0] sdx, input logic [CW-1:0] sdy);
        x0 = sx0; y0 = sy0; dx = sdx; dy = sdy;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_it_val", bus.it_val, 1);
    endtask

    // One pixel: coordinate handshake, one cycle of iterator latency, result, optional write handshake.
    task automatic do_pixel(input vec_t v, input int idx, input bit finish_write);
        int guard;
        guard = 0;
        while (!bus.it_val && guard < 20) begin
            step();
            guard++;
        end
        chk("it_val_wait", bus.it_val, 1);
        chk("it_c_r", bus.it_c_r, v.c_r);
        chk("it_c_i", bus.it_c_i, v.c_i);
        for (int k = 0; k < v.rdy_stall; k++) begin
            step();
            chk("stall_it_val", bus.it_val, 1);
            chk("stall_c_r", bus.it_c_r, v.c_r);
            chk("stall_c_i", bus.it_c_i, v.c_i);
        end
        bus.it_rdy = 1'b1;
        step();
        bus.it_rdy = 1'b0;
        chk("it_val_drop", bus.it_val, 0);
        chk("out_rdy_rise", bus.it_out_rdy, 1);
        step();
        chk("out_rdy_hold", bus.it_out_rdy, 1);
        bus.it_out_val    = 1'b1;
        bus.it_iter_count = v.iter;
        bus.it_escape     = v.esc;
        step();
        bus.it_out_val    = 1'b0;
        bus.it_iter_count = '1;
        bus.it_escape     = ~v.esc;
        chk("pix_val_rise", bus.pix_val, 1);
        chk("pix_addr", bus.pix_addr, idx);
        chk("pix_iter", bus.pix_iter, v.iter);
        chk("pix_escape", bus.pix_escape, v.esc);
        chk("out_rdy_drop", bus.it_out_rdy, 0);
        for (int k = 0; k < v.pix_stall; k++) begin
            step();
            chk("bp_pix_val", bus.pix_val, 1);
            chk("bp_pix_addr", bus.pix_addr, idx);
            chk("bp_pix_iter", bus.pix_iter, v.iter);
            chk("bp_pix_esc", bus.pix_escape, v.esc);
            chk("bp_it_val", bus.it_val, 0);
        end
        if (finish_write) begin
            bus.pix_rdy = 1'b1;
            step();
            bus.pix_rdy = 1'b0;
            chk("pix_val_drop", bus.pix_val, 0);
        end
    endtask

    task automatic run_frame(input int fd_expect);
        for (int i = 0; i < 8; i++) begin
            do_pixel(tbl[i], i, 1'b1);
            if (i < 7) begin
                chk("mid_frame_done", frame_done, 0);
                chk("mid_busy", busy, 1);
                chk("next_it_val", bus.it_val, 1);
            end
        end
        chk("frame_done_pulse", frame_done, 1);
        chk("end_busy", busy, 0);
        step();
        chk("frame_done_single", frame_done, 0);
        chk("fd_count", fd_count, fd_expect);
    endtask

    localparam logic [CW-1:0] M2  = 27'h7000000;
    localparam logic [CW-1:0] M1  = 27'h7800000;
    localparam logic [CW-1:0] P1  = 27'h0800000;
    localparam logic [CW-1:0] HLF = 27'h0400000;

    initial begin
        vec_t w0, w1;
        int   p0;

        //         c_r  c_i  iter  esc rdy_stall pix_stall
        tbl[0] = '{M2,  '0,  0,    1,  0,  0};
        tbl[1] = '{M1,  '0,  1,    1,  0,  10};
        tbl[2] = '{'0,  '0,  1000, 0,  10, 0};
        tbl[3] = '{P1,  '0,  3,    1,  0,  0};
        tbl[4] = '{M2,  HLF, 0,    1,  0,  0};
        tbl[5] = '{M1,  HLF, 1,    1,  2,  3};
        tbl[6] = '{'0,  HLF, 2,    0,  0,  0};
        tbl[7] = '{P1,  HLF, 3,    1,  0,  0};

        reset = 1'b0; start = 1'b0; abort = 1'b0;
        x0 = '0; y0 = '0; dx = '0; dy = '0;
        bus.it_rdy = 1'b0; bus.it_out_val = 1'b0; bus.it_iter_count = '0;
        bus.it_escape = 1'b0; bus.pix_rdy = 1'b0;

        // reset state
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_it_val", bus.it_val, 0);
        chk("rst_out_rdy", bus.it_out_rdy, 0);
        chk("rst_pix_val", bus.pix_val, 0);
        chk("rst_pix_addr", bus.pix_addr, 0);
        chk("rst_c_r", bus.it_c_r, 0);
        repeat (2) step();
        reset = 1'b1;
        step();
        chk("idle_busy", busy, 0);

        // full frame with backpressure and iterator stalls
        start_frame(M2, '0, P1, HLF);
        run_frame(1);

        // abort while waiting on the iterator, then restart from the origin
        start_frame(M2, '0, P1, HLF);
        do_pixel(tbl[0], 0, 1'b1);
        do_pixel(tbl[1], 1, 1'b1);
        chk("ab_c_r", bus.it_c_r, 27'h0);
        bus.it_rdy = 1'b1;
        step();
        bus.it_rdy = 1'b0;
        p0 = pix_cnt;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_out_rdy_held", bus.it_out_rdy, 1);
        chk("ab_busy_held", busy, 1);
        repeat (2) step();
        bus.it_out_val = 1'b1;
        bus.it_iter_count = 11'd7;
        step();
        bus.it_out_val = 1'b0;
        chk("ab_busy_fall", busy, 0);
        chk("ab_out_rdy_fall", bus.it_out_rdy, 0);
        chk("ab_pix_val", bus.pix_val, 0);
        repeat (3) step();
        chk("ab_no_pix", pix_cnt, p0);
        chk("ab_no_frame_done", fd_count, 1);
        start_frame(M2, '0, P1, HLF);
        chk("restart_c_r", bus.it_c_r, M2);
        chk("restart_addr", bus.pix_addr, 0);

        // abort in ISSUE before the coordinate is taken
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        chk("ab_issue_busy", busy, 0);
        chk("ab_issue_it_val", bus.it_val, 0);

        // accumulator wrap, then abort while a write is pending
        start_frame(27'h3FFFFFF, '0, 27'h1, '0);
        w0 = '{27'h3FFFFFF, '0, 5, 1, 0, 0};
        w1 = '{27'h4000000, '0, 6, 0, 0, 2};
        do_pixel(w0, 0, 1'b1);
        do_pixel(w1, 1, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abw_pix_val_held", bus.pix_val, 1);
        chk("abw_addr_held", bus.pix_addr, 1);
        bus.pix_rdy = 1'b1;
        step();
        bus.pix_rdy = 1'b0;
        chk("abw_busy", busy, 0);
        chk("abw_pix_val", bus.pix_val, 0);
        chk("abw_it_val", bus.it_val, 0);
        chk("abw_frame_done", frame_done, 0);

        // start while busy is ignored; async reset in WRITE clears everything
        start_frame(M2, '0, P1, HLF);
        do_pixel(tbl[0], 0, 1'b1);
        x0 = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        do_pixel(tbl[1], 1, 1'b1);
        do_pixel(tbl[2], 2, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_pix_val", bus.pix_val, 0);
        chk("arst_busy", busy, 0);
        chk("arst_pix_addr", bus.pix_addr, 0);
        chk("arst_pix_iter", bus.pix_iter, 0);
        chk("arst_c_i", bus.it_c_i, 0);
        step();
        reset = 1'b1;
        step();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_it_val", bus.it_val, 0);
        start_frame(M2, '0, P1, HLF);
        run_frame(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
